// File: rtl/fetch_pc_ctrl.sv
// rtl/fetch_pc_ctrl.sv - instruction fetch PC sequencer with one-entry output buffer
//
// Purpose:
//   Owns the architectural fetch PC and picks the next PC. Redirect sources
//   in priority order are a certain branch from EX, then ROB recovery.
//   On a cache hit the next PC comes from the predictor or from PC+4.
//   The block drives the Icache address and request. It selects the 32-bit
//   instruction from the 64-bit line and holds it in a one-entry buffer
//   with a valid/ready handshake toward decode.
//
// Ports:
//   clock, reset                      - clock, synchronous active-high reset
//   if_valid                          - decode ready (accepts when fetch_valid=1)
//   certain_branch_req/_pc            - resolved taken branch redirect from EX
//   rob_target_req/_pc                - ROB recovery redirect
//   branch_pred_req/_pc               - predicted-taken target for the fetched PC
//   Icache2proc_data/_data_valid      - Icache line and hit for proc2Icache_addr
//   proc2Icache_addr/_req             - Icache line address and request (combinational)
//   fetch_valid/_inst/_pc/_npc        - output buffer toward decode
//   fetch_cnt, redirect_cnt           - delivered-instruction and redirect counters
module fetch_pc_ctrl #(
  parameter int               XLEN     = 32,
  parameter logic [XLEN-1:0]  RESET_PC = '0,
  parameter int               CNT_W    = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             if_valid,
  input  logic             certain_branch_req,
  input  logic [XLEN-1:0]  certain_branch_pc,
  input  logic             rob_target_req,
  input  logic [XLEN-1:0]  rob_target_pc,
  input  logic             branch_pred_req,
  input  logic [XLEN-1:0]  branch_pred_pc,
  input  logic [63:0]      Icache2proc_data,
  input  logic             Icache2proc_data_valid,
  output logic [XLEN-1:0]  proc2Icache_addr,
  output logic             proc2Icache_req,
  output logic             fetch_valid,
  output logic [31:0]      fetch_inst,
  output logic [XLEN-1:0]  fetch_pc,
  output logic [XLEN-1:0]  fetch_npc,
  output logic [CNT_W-1:0] fetch_cnt,
  output logic [CNT_W-1:0] redirect_cnt
);

  typedef enum logic {S_FETCH, S_HOLD} state_t;

  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);
  localparam logic [XLEN-1:0] LINE_MASK  = ~XLEN'(7);

  state_t            r_state;
  state_t            w_state_next;
  logic [XLEN-1:0]   r_pc;
  logic              r_fetch_valid;
  logic [31:0]       r_fetch_inst;
  logic [XLEN-1:0]   r_fetch_pc;
  logic [XLEN-1:0]   r_fetch_npc;
  logic [CNT_W-1:0]  r_fetch_cnt;
  logic [CNT_W-1:0]  r_redirect_cnt;

  logic              w_load_ok;
  logic              w_req;
  logic              w_redirect;
  logic [XLEN-1:0]   w_redirect_pc;
  logic              w_hit;
  logic              w_accept;
  logic [XLEN-1:0]   w_npc;

  assign w_load_ok     = !r_fetch_valid || if_valid;
  assign w_req         = (r_state == S_FETCH) && w_load_ok && !reset;
  assign w_redirect    = certain_branch_req || rob_target_req;
  assign w_redirect_pc = (certain_branch_req ? certain_branch_pc : rob_target_pc) & ALIGN_MASK;
  // A redirect in the same cycle kills both the hit and the accept.
  assign w_hit         = w_req && Icache2proc_data_valid && !w_redirect;
  assign w_accept      = r_fetch_valid && if_valid && !w_redirect;
  assign w_npc         = branch_pred_req ? (branch_pred_pc & ALIGN_MASK) : (r_pc + XLEN'(4));

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_FETCH: if (!w_redirect && r_fetch_valid && !if_valid) w_state_next = S_HOLD;
      S_HOLD:  if (w_redirect || if_valid) w_state_next = S_FETCH;
      default: w_state_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state        <= S_FETCH;
      r_pc           <= RESET_PC;
      r_fetch_valid  <= 1'b0;
      r_fetch_inst   <= '0;
      r_fetch_pc     <= '0;
      r_fetch_npc    <= '0;
      r_fetch_cnt    <= '0;
      r_redirect_cnt <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_redirect) begin
        r_pc           <= w_redirect_pc;
        r_fetch_valid  <= 1'b0;
        r_redirect_cnt <= r_redirect_cnt + CNT_W'(1);
      end else begin
        if (w_hit) begin
          r_fetch_inst  <= r_pc[2] ? Icache2proc_data[63:32] : Icache2proc_data[31:0];
          r_fetch_pc    <= r_pc;
          r_fetch_npc   <= w_npc;
          r_pc          <= w_npc;
          r_fetch_valid <= 1'b1;
        end else if (w_accept) begin
          r_fetch_valid <= 1'b0;
        end
        if (w_accept) r_fetch_cnt <= r_fetch_cnt + CNT_W'(1);
      end
    end
  end

  assign proc2Icache_addr = r_pc & LINE_MASK;
  assign proc2Icache_req  = w_req;
  assign fetch_valid      = r_fetch_valid;
  assign fetch_inst       = r_fetch_inst;
  assign fetch_pc         = r_fetch_pc;
  assign fetch_npc        = r_fetch_npc;
  assign fetch_cnt        = r_fetch_cnt;
  assign redirect_cnt     = r_redirect_cnt;

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// tb/tb_fetch_pc_ctrl.sv - directed self-checking bench for fetch_pc_ctrl
module tb_fetch_pc_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        if_valid;
  logic        certain_branch_req;
  logic [31:0] certain_branch_pc;
  logic        rob_target_req;
  logic [31:0] rob_target_pc;
  logic        branch_pred_req;
  logic [31:0] branch_pred_pc;
  logic [63:0] Icache2proc_data;
  logic        Icache2proc_data_valid;
  logic [31:0] proc2Icache_addr;
  logic        proc2Icache_req;
  logic        fetch_valid;
  logic [31:0] fetch_inst;
  logic [31:0] fetch_pc;
  logic [31:0] fetch_npc;
  logic [31:0] fetch_cnt;
  logic [31:0] redirect_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_pc_ctrl #(.XLEN(32), .RESET_PC(32'h0), .CNT_W(32)) dut (
    .clock                  (clock),
    .reset                  (reset),
    .if_valid               (if_valid),
    .certain_branch_req     (certain_branch_req),
    .certain_branch_pc      (certain_branch_pc),
    .rob_target_req         (rob_target_req),
    .rob_target_pc          (rob_target_pc),
    .branch_pred_req        (branch_pred_req),
    .branch_pred_pc         (branch_pred_pc),
    .Icache2proc_data       (Icache2proc_data),
    .Icache2proc_data_valid (Icache2proc_data_valid),
    .proc2Icache_addr       (proc2Icache_addr),
    .proc2Icache_req        (proc2Icache_req),
    .fetch_valid            (fetch_valid),
    .fetch_inst             (fetch_inst),
    .fetch_pc               (fetch_pc),
    .fetch_npc              (fetch_npc),
    .fetch_cnt              (fetch_cnt),
    .redirect_cnt           (redirect_cnt)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    if_valid = 1'b1;
    certain_branch_req = 1'b0; certain_branch_pc = '0;
    rob_target_req = 1'b0;     rob_target_pc = '0;
    branch_pred_req = 1'b0;    branch_pred_pc = '0;
    Icache2proc_data = 64'h22222222_11111111;
    Icache2proc_data_valid = 1'b1;
    tick();
    tick();
    n_checks++; if (proc2Icache_req !== 1'b0) begin n_fail++; $display("FAIL rst_req got %h want 0", proc2Icache_req); end
    n_checks++; if (fetch_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %h want 0", fetch_valid); end
    n_checks++; if (fetch_inst !== 32'h0) begin n_fail++; $display("FAIL rst_inst got %h want 0", fetch_inst); end
    n_checks++; if (fetch_pc !== 32'h0) begin n_fail++; $display("FAIL rst_pc got %h want 0", fetch_pc); end
    n_checks++; if (fetch_npc !== 32'h0) begin n_fail++; $display("FAIL rst_npc got %h want 0", fetch_npc); end
    n_checks++; if (fetch_cnt !== 32'h0) begin n_fail++; $display("FAIL rst_fcnt got %h want 0", fetch_cnt); end
    n_checks++; if (redirect_cnt !== 32'h0) begin n_fail++; $display("FAIL rst_rcnt got %h want 0", redirect_cnt); end
    n_checks++; if (proc2Icache_addr !== 32'h0) begin n_fail++; $display("FAIL rst_addr got %h want 0", proc2Icache_addr); end
  endtask

  task automatic test_sequential();
    reset = 1'b0;
    #1;
    n_checks++; if (proc2Icache_req !== 1'b1) begin n_fail++; $display("FAIL seq_req0 got %h want 1", proc2Icache_req); end
    n_checks++; if (proc2Icache_addr !== 32'h0) begin n_fail++; $display("FAIL seq_addr0 got %h want 0", proc2Icache_addr); end
    tick();
    n_checks++; if (fetch_inst !== 32'h11111111) begin n_fail++; $display("FAIL seq_inst0 got %h want 11111111", fetch_inst); end
    n_checks++; if (fetch_pc !== 32'h0) begin n_fail++; $display("FAIL seq_pc0 got %h want 0", fetch_pc); end
    n_checks++; if (fetch_npc !== 32'h4) begin n_fail++; $display("FAIL seq_npc0 got %h want 4", fetch_npc); end
    n_checks++; if (fetch_valid !== 1'b1) begin n_fail++; $display("FAIL seq_valid0 got %h want 1", fetch_valid); end
    n_checks++; if (fetch_cnt !== 32'd0) begin n_fail++; $display("FAIL seq_cnt0 got %0d want 0", fetch_cnt); end
    n_checks++; if (proc2Icache_req !== 1'b1) begin n_fail++; $display("FAIL seq_req1 got %h want 1", proc2Icache_req); end
    tick();
    n_checks++; if (fetch_inst !== 32'h22222222) begin n_fail++; $display("FAIL seq_inst1 got %h want 22222222", fetch_inst); end
    n_checks++; if (fetch_pc !== 32'h4) begin n_fail++; $display("FAIL seq_pc1 got %h want 4", fetch_pc); end
    n_checks++; if (fetch_cnt !== 32'd1) begin n_fail++; $display("FAIL seq_cnt1 got %0d want 1", fetch_cnt); end
    n_checks++; if (proc2Icache_addr !== 32'h8) begin n_fail++; $display("FAIL seq_addr2 got %h want 8", proc2Icache_addr); end
    tick();
    n_checks++; if (fetch_inst !== 32'h11111111) begin n_fail++; $display("FAIL seq_inst2 got %h want 11111111", fetch_inst); end
    n_checks++; if (fetch_pc !== 32'h8) begin n_fail++; $display("FAIL seq_pc2 got %h want 8", fetch_pc); end
    n_checks++; if (fetch_cnt !== 32'd2) begin n_fail++; $display("FAIL seq_cnt2 got %0d want 2", fetch_cnt); end
  endtask

  task automatic test_redirect_priority();
    certain_branch_req = 1'b1; certain_branch_pc = 32'h11111111;
    rob_target_req = 1'b1;     rob_target_pc = 32'h22222222;
    branch_pred_req = 1'b1;    branch_pred_pc = 32'h33333333;
    tick();
    certain_branch_req = 1'b0; rob_target_req = 1'b0; branch_pred_req = 1'b0;
    #1;
    n_checks++; if (proc2Icache_addr !== 32'h11111110) begin n_fail++; $display("FAIL prio_addr got %h want 11111110", proc2Icache_addr); end
    n_checks++; if (fetch_valid !== 1'b0) begin n_fail++; $display("FAIL prio_valid got %h want 0", fetch_valid); end
    n_checks++; if (redirect_cnt !== 32'd1) begin n_fail++; $display("FAIL prio_rcnt got %0d want 1", redirect_cnt); end
    n_checks++; if (fetch_cnt !== 32'd2) begin n_fail++; $display("FAIL prio_fcnt got %0d want 2", fetch_cnt); end
  endtask

  task automatic test_predict();
    certain_branch_req = 1'b1; certain_branch_pc = 32'h100;
    tick();
    certain_branch_req = 1'b0;
    branch_pred_req = 1'b1; branch_pred_pc = 32'h200;
    Icache2proc_data = 64'hAAAAAAAA_BBBBBBBB;
    #1;
    n_checks++; if (proc2Icache_addr !== 32'h100) begin n_fail++; $display("FAIL pred_addr0 got %h want 100", proc2Icache_addr); end
    tick();
    branch_pred_req = 1'b0;
    #1;
    n_checks++; if (fetch_pc !== 32'h100) begin n_fail++; $display("FAIL pred_pc got %h want 100", fetch_pc); end
    n_checks++; if (fetch_npc !== 32'h200) begin n_fail++; $display("FAIL pred_npc got %h want 200", fetch_npc); end
    n_checks++; if (fetch_inst !== 32'hBBBBBBBB) begin n_fail++; $display("FAIL pred_inst got %h want bbbbbbbb", fetch_inst); end
    n_checks++; if (proc2Icache_addr !== 32'h200) begin n_fail++; $display("FAIL pred_addr1 got %h want 200", proc2Icache_addr); end
    n_checks++; if (redirect_cnt !== 32'd2) begin n_fail++; $display("FAIL pred_rcnt got %0d want 2", redirect_cnt); end
  endtask

  task automatic test_hold();
    if_valid = 1'b0;
    #1;
    n_checks++; if (proc2Icache_req !== 1'b0) begin n_fail++; $display("FAIL hold_req0 got %h want 0", proc2Icache_req); end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (proc2Icache_req !== 1'b0) begin n_fail++; $display("FAIL hold_req[%0d] got %h want 0", i, proc2Icache_req); end
      n_checks++; if (fetch_valid !== 1'b1) begin n_fail++; $display("FAIL hold_valid[%0d] got %h want 1", i, fetch_valid); end
      n_checks++; if (fetch_pc !== 32'h100) begin n_fail++; $display("FAIL hold_pc[%0d] got %h want 100", i, fetch_pc); end
      n_checks++; if (fetch_inst !== 32'hBBBBBBBB) begin n_fail++; $display("FAIL hold_inst[%0d] got %h want bbbbbbbb", i, fetch_inst); end
      n_checks++; if (fetch_cnt !== 32'd2) begin n_fail++; $display("FAIL hold_cnt[%0d] got %0d want 2", i, fetch_cnt); end
    end
    if_valid = 1'b1;
    tick();
    n_checks++; if (fetch_cnt !== 32'd3) begin n_fail++; $display("FAIL hold_rel_cnt got %0d want 3", fetch_cnt); end
    n_checks++; if (proc2Icache_req !== 1'b1) begin n_fail++; $display("FAIL hold_rel_req got %h want 1", proc2Icache_req); end
    n_checks++; if (fetch_valid !== 1'b0) begin n_fail++; $display("FAIL hold_rel_valid got %h want 0", fetch_valid); end
    n_checks++; if (proc2Icache_addr !== 32'h200) begin n_fail++; $display("FAIL hold_rel_addr got %h want 200", proc2Icache_addr); end
  endtask

  task automatic test_miss();
    certain_branch_req = 1'b1; certain_branch_pc = 32'h40;
    Icache2proc_data_valid = 1'b0;
    tick();
    certain_branch_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++; if (proc2Icache_addr !== 32'h40) begin n_fail++; $display("FAIL miss_addr[%0d] got %h want 40", i, proc2Icache_addr); end
      n_checks++; if (fetch_valid !== 1'b0) begin n_fail++; $display("FAIL miss_valid[%0d] got %h want 0", i, fetch_valid); end
      n_checks++; if (proc2Icache_req !== 1'b1) begin n_fail++; $display("FAIL miss_req[%0d] got %h want 1", i, proc2Icache_req); end
    end
    Icache2proc_data_valid = 1'b1;
    Icache2proc_data = 64'hCAFEF00D_DEADBEEF;
    tick();
    n_checks++; if (fetch_valid !== 1'b1) begin n_fail++; $display("FAIL miss_done_valid got %h want 1", fetch_valid); end
    n_checks++; if (fetch_inst !== 32'hDEADBEEF) begin n_fail++; $display("FAIL miss_done_inst got %h want deadbeef", fetch_inst); end
    n_checks++; if (fetch_pc !== 32'h40) begin n_fail++; $display("FAIL miss_done_pc got %h want 40", fetch_pc); end
    n_checks++; if (fetch_npc !== 32'h44) begin n_fail++; $display("FAIL miss_done_npc got %h want 44", fetch_npc); end
    n_checks++; if (redirect_cnt !== 32'd3) begin n_fail++; $display("FAIL miss_rcnt got %0d want 3", redirect_cnt); end
  endtask

  task automatic test_rob_flush();
    rob_target_req = 1'b1; rob_target_pc = 32'h83;
    tick();
    rob_target_req = 1'b0;
    #1;
    n_checks++; if (fetch_valid !== 1'b0) begin n_fail++; $display("FAIL rob_valid got %h want 0", fetch_valid); end
    n_checks++; if (fetch_cnt !== 32'd3) begin n_fail++; $display("FAIL rob_fcnt got %0d want 3", fetch_cnt); end
    n_checks++; if (redirect_cnt !== 32'd4) begin n_fail++; $display("FAIL rob_rcnt got %0d want 4", redirect_cnt); end
    n_checks++; if (proc2Icache_addr !== 32'h80) begin n_fail++; $display("FAIL rob_addr got %h want 80", proc2Icache_addr); end
    n_checks++; if (fetch_pc !== 32'h40) begin n_fail++; $display("FAIL rob_pc_kept got %h want 40", fetch_pc); end
    tick();
    n_checks++; if (fetch_pc !== 32'h80) begin n_fail++; $display("FAIL rob_next_pc got %h want 80", fetch_pc); end
    n_checks++; if (fetch_npc !== 32'h84) begin n_fail++; $display("FAIL rob_next_npc got %h want 84", fetch_npc); end
  endtask

  task automatic test_wrap();
    certain_branch_req = 1'b1; certain_branch_pc = 32'hFFFFFFFC;
    tick();
    certain_branch_req = 1'b0;
    Icache2proc_data = 64'h12345678_9ABCDEF0;
    #1;
    n_checks++; if (proc2Icache_addr !== 32'hFFFFFFF8) begin n_fail++; $display("FAIL wrap_addr0 got %h want fffffff8", proc2Icache_addr); end
    n_checks++; if (fetch_cnt !== 32'd3) begin n_fail++; $display("FAIL wrap_fcnt got %0d want 3", fetch_cnt); end
    tick();
    n_checks++; if (fetch_inst !== 32'h12345678) begin n_fail++; $display("FAIL wrap_inst got %h want 12345678", fetch_inst); end
    n_checks++; if (fetch_pc !== 32'hFFFFFFFC) begin n_fail++; $display("FAIL wrap_pc got %h want fffffffc", fetch_pc); end
    n_checks++; if (fetch_npc !== 32'h0) begin n_fail++; $display("FAIL wrap_npc got %h want 0", fetch_npc); end
    n_checks++; if (proc2Icache_addr !== 32'h0) begin n_fail++; $display("FAIL wrap_addr1 got %h want 0", proc2Icache_addr); end
    n_checks++; if (redirect_cnt !== 32'd5) begin n_fail++; $display("FAIL wrap_rcnt got %0d want 5", redirect_cnt); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_redirect_priority();
    test_predict();
    test_hold();
    test_miss();
    test_rob_flush();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_pc_ctrl.md
Name: fetch_pc_ctrl

Overview:
- Sequences the instruction-fetch front end. Owns the architectural fetch PC and arbitrates between next-PC sources: certain branch from EX, ROB recovery target, branch predictor, and sequential PC+4.
- Drives the Icache address and request.
- Extracts the 32-bit instruction from the 64-bit Icache line and holds it in a one-entry output buffer with a valid/ready handshake toward decode.

Parameters:
XLEN, 32, address width.
RESET_PC, 0, fetch PC loaded on reset.
CNT_W, 32, width of performance counters.

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
if_valid  in  1  decode ready; fetched instruction accepted this cycle when fetch_valid=1
certain_branch_req  in  1  resolved taken branch from EX
certain_branch_pc  in  XLEN  EX target
rob_target_req  in  1  ROB recovery redirect
rob_target_pc  in  XLEN  ROB target
branch_pred_req  in  1  predictor says the instruction being fetched is predicted taken
branch_pred_pc  in  XLEN  predicted target
Icache2proc_data  in  64  line data for the address driven this cycle
Icache2proc_data_valid  in  1  data valid (hit) for the current proc2Icache_addr
proc2Icache_addr  out  XLEN  {pc_reg[XLEN-1:3],3'b000}
proc2Icache_req  out  1  fetch request
fetch_valid  out  1  output buffer holds an instruction
fetch_inst  out  32  instruction
fetch_pc  out  XLEN  PC of fetch_inst
fetch_npc  out  XLEN  PC chosen to follow fetch_inst
fetch_cnt  out  CNT_W  instructions delivered (accepted by decode)
redirect_cnt  out  CNT_W  redirects taken (certain or ROB)

Behaviour:
- Reset (clock edge with reset=1):
  - pc_reg=RESET_PC; state=FETCH.
  - fetch_valid=0; fetch_inst, fetch_pc, fetch_npc=0.
  - Both counters=0.
  - proc2Icache_req=0 while reset is high.
  - Reset overrides every other input in the same cycle.
- States:
  - FETCH: request issued.
  - HOLD: buffer full and decode not ready; no request.
  - load_ok = !fetch_valid | if_valid.
  - FETCH→HOLD when an instruction is loaded and the next cycle has fetch_valid=1 & if_valid=0. HOLD→FETCH on if_valid=1.
  - A redirect always returns to FETCH.
- proc2Icache_req = (state==FETCH) & load_ok & !reset.
- Redirect priority: certain_branch_req > rob_target_req. Either one:
  - pc_reg <= target with bits[1:0] forced to 0;
  - fetch_valid <= 0 (buffered instruction flushed even if if_valid=1 that cycle; it is not counted);
  - any Icache response in that cycle is dropped;
  - redirect_cnt += 1;
  - new address appears on proc2Icache_addr the next cycle (1-cycle redirect latency).
- Hit: proc2Icache_req & Icache2proc_data_valid with no redirect. On the next edge:
  - fetch_inst = pc_reg[2] ? data[63:32] : data[31:0];
  - fetch_pc = pc_reg;
  - fetch_npc = branch_pred_req ? {branch_pred_pc[XLEN-1:2],2'b00} : pc_reg+4 (mod 2^XLEN, wrap allowed);
  - pc_reg = fetch_npc; fetch_valid = 1.
  - Throughput is 1 instruction/cycle on back-to-back hits.
- branch_pred_req is ignored unless a hit occurs in that cycle.
- Miss (req=1, data_valid=0): pc_reg holds and req stays asserted; there is no timeout.
- Accept (fetch_valid & if_valid, no redirect):
  - fetch_cnt += 1;
  - the buffer empties unless reloaded by a simultaneous hit (load and accept in the same cycle is legal).
- Counters wrap at 2^CNT_W.
- Outputs are registered except proc2Icache_addr and proc2Icache_req.

Test Plan:
- Reset with RESET_PC=0x0; hold data_valid=1, data=0x22222222_11111111, if_valid=1 → proc2Icache_addr=0x0 on the first cycle after reset. Next cycle: fetch_inst=0x11111111, fetch_pc=0, fetch_npc=4. Following cycle: fetch_inst=0x22222222, fetch_pc=4. fetch_cnt increments each cycle.
- certain_branch_pc=0x11111111, rob_target_pc=0x22222222, branch_pred_pc=0x33333333, all req=1 in the same cycle → next cycle proc2Icache_addr=0x11111110 (pc_reg=0x11111110), fetch_valid=0, redirect_cnt=1.
- Hit at pc=0x100 with branch_pred_req=1, branch_pred_pc=0x200 → fetch_pc=0x100, fetch_npc=0x200. Next proc2Icache_addr=0x200.
- if_valid=0 with buffer full → HOLD, proc2Icache_req=0, outputs stable across 3 cycles. if_valid=1 → fetch_cnt+1, req=1 the same cycle.
- data_valid=0 for 5 cycles at 0x40 → addr stays 0x40, fetch_valid stays 0. data_valid=1 → instruction delivered the next cycle.
- rob_target_req=1 (0x80) in the same cycle as a hit and an accept → the hit is dropped, fetch_cnt unchanged, fetch_valid=0, next addr=0x80.
